// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder controller.
// Holds the FSM state encoding and the default operand width.
// Imported by serial_add_ctrl; fa_bit has no dependency on it.
package serial_add_pkg;

    // Controller state encoding.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Default operand/sum width; legal range 1..32.
    localparam int DEFAULT_WIDTH = 8;

endpackage : serial_add_pkg

// File: rtl/serial_add_ctrl_fa_bit.sv
// Combinational 1-bit full adder cell shared by the serial controller.
// Ports: a, b, ci (inputs); s (sum), co (carry out).
// Latency: zero (purely combinational); no flow control.
module fa_bit (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (a & ci) | (b & ci);

endmodule : fa_bit

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: sequences one fa_bit cell over WIDTH cycles, LSB first.
// Latency: done pulses WIDTH+1 cycles after the accepting edge; one result per WIDTH+2 cycles.
// Backpressure: start is only sampled in IDLE; no queueing, requester holds or re-issues start.
//
// Ports: sys_clk, sys_rst (sync, active-high); start, op_a, op_b, cin request
// inputs; sub (only with SERIAL_ADD_SUB_EN defined) selects op_a - op_b;
// busy, done, sum, cout result outputs (sum/cout held until next accepted start).
// Optional feature macro: SERIAL_ADD_SUB_EN.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q,  a_sh_d;
    logic [WIDTH-1:0] b_sh_q,  b_sh_d;
    logic [WIDTH-1:0] sum_q,   sum_d;
    logic             c_r_q,   c_r_d;
    logic [CW-1:0]    cnt_q,   cnt_d;
    logic             done_q,  done_d;
    logic             cout_q,  cout_d;

    logic             fa_s;
    logic             fa_co;

    // The single shared adder cell always sees the current LSBs and carry.
    fa_bit u_fa (
        .a  (a_sh_q[0]),
        .b  (b_sh_q[0]),
        .ci (c_r_q),
        .s  (fa_s),
        .co (fa_co)
    );

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        sum_d   = sum_q;
        c_r_d   = c_r_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        cout_d  = cout_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_sh_d = op_a;
`ifdef SERIAL_ADD_SUB_EN
                    // Subtract as op_a + ~op_b + 1; cin is ignored.
                    if (sub) begin
                        b_sh_d = ~op_b;
                        c_r_d  = 1'b1;
                    end else begin
                        b_sh_d = op_b;
                        c_r_d  = cin;
                    end
`else
                    b_sh_d = op_b;
                    c_r_d  = cin;
`endif
                    cnt_d   = '0;
                    sum_d   = '0;
                    state_d = ST_RUN;
                end
            end

            ST_RUN: begin
                // Sum bits enter at the MSB and walk down; after WIDTH
                // shifts bit 0 of the operands lands in sum[0].
                sum_d            = sum_q >> 1;
                sum_d[WIDTH-1]   = fa_s;
                c_r_d            = fa_co;
                a_sh_d           = a_sh_q >> 1;
                b_sh_d           = b_sh_q >> 1;
                cnt_d            = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_DONE;
                end
            end

            ST_DONE: begin
                // done/cout are registered here, so the pulse appears in the
                // first IDLE cycle, while sum is still stable.
                done_d  = 1'b1;
                cout_d  = c_r_q;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q <= ST_IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            sum_q   <= '0;
            c_r_q   <= 1'b0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            sum_q   <= sum_d;
            c_r_q   <= c_r_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            cout_q  <= cout_d;
        end
    end

    assign busy = (state_q == ST_RUN) || (state_q == ST_DONE);
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule : serial_add_ctrl
